// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } hazard_state_e;

    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam logic [4:0]  REG_X0   = 5'd0;

    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory handshake FSM: holds DMem_Req until ack, freezes the pipe while waiting,
// and parks in ERROR once the wait exceeds MEM_TIMEOUT cycles.
module dmem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_op_i,
    input  logic dmem_ack_i,
    output logic dmem_req_o,
    output logic freeze_o,
    output logic mem_timeout_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    hazard_state_e    state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        dmem_req_o    = 1'b0;
        freeze_o      = 1'b0;
        mem_timeout_o = 1'b0;
        case (state_q)
            RUN: begin
                // An ack in the issue cycle is ignored, so every access costs at least 2 cycles.
                if (mem_op_i) begin
                    dmem_req_o = 1'b1;
                    freeze_o   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end else begin
                    freeze_o = 1'b1;
                    if (wait_cnt_q == WaitLast) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
                end
            end
            ERROR: begin
                freeze_o      = 1'b1;
                mem_timeout_o = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, branch redirect flush,
// load-use bubble, plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             IF_ID_UsesRs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             Branch_Taken,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             DMem_Ack,
    output logic             DMem_Req,
    output logic             PC_Write,
    output logic             IF_ID_Stall,
    output logic             IF_ID_Flush,
    output logic             Control_Sig_Stall,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Stall,
    output logic             MEM_WB_Bubble,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    logic mem_op;
    logic freeze;
    logic load_use;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign mem_op = is_mem_op(EX_MEM_MemRead, EX_MEM_MemWrite);

    dmem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_dmem_wait_fsm (
        .clk          (clk),
        .reset        (reset),
        .mem_op_i     (mem_op),
        .dmem_ack_i   (DMem_Ack),
        .dmem_req_o   (DMem_Req),
        .freeze_o     (freeze),
        .mem_timeout_o(Mem_Timeout)
    );

    assign load_use = ID_EX_MemRead && (ID_EX_Rd != REG_X0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) || (IF_ID_UsesRs2 && (ID_EX_Rd == IF_ID_Rs2)));

    // Freeze wins over everything; a held Branch_Taken is serviced once the freeze lifts.
    always_comb begin
        PC_Write          = 1'b1;
        IF_ID_Stall       = 1'b0;
        IF_ID_Flush       = 1'b0;
        Control_Sig_Stall = 1'b0;
        ID_EX_Bubble      = 1'b0;
        EX_MEM_Stall      = 1'b0;
        MEM_WB_Bubble     = 1'b0;
        if (freeze) begin
            PC_Write          = 1'b0;
            IF_ID_Stall       = 1'b1;
            Control_Sig_Stall = 1'b1;
            EX_MEM_Stall      = 1'b1;
            MEM_WB_Bubble     = 1'b1;
        end else if (Branch_Taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Stall  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!PC_Write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IF_ID_Flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters).
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] IF_ID_Rs1;
    logic [4:0] IF_ID_Rs2;
    logic       IF_ID_UsesRs2;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_Rd;
    logic       Branch_Taken;
    logic       EX_MEM_MemRead;
    logic       EX_MEM_MemWrite;
    logic       DMem_Ack;
    logic       DMem_Req;
    logic       PC_Write;
    logic       IF_ID_Stall;
    logic       IF_ID_Flush;
    logic       Control_Sig_Stall;
    logic       ID_EX_Bubble;
    logic       EX_MEM_Stall;
    logic       MEM_WB_Bubble;
    logic       Mem_Timeout;
    logic [3:0] Stall_Count;
    logic [3:0] Flush_Count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_Rs1        (IF_ID_Rs1),
        .IF_ID_Rs2        (IF_ID_Rs2),
        .IF_ID_UsesRs2    (IF_ID_UsesRs2),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_Rd         (ID_EX_Rd),
        .Branch_Taken     (Branch_Taken),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .DMem_Ack         (DMem_Ack),
        .DMem_Req         (DMem_Req),
        .PC_Write         (PC_Write),
        .IF_ID_Stall      (IF_ID_Stall),
        .IF_ID_Flush      (IF_ID_Flush),
        .Control_Sig_Stall(Control_Sig_Stall),
        .ID_EX_Bubble     (ID_EX_Bubble),
        .EX_MEM_Stall     (EX_MEM_Stall),
        .MEM_WB_Bubble    (MEM_WB_Bubble),
        .Mem_Timeout      (Mem_Timeout),
        .Stall_Count      (Stall_Count),
        .Flush_Count      (Flush_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a posedge; outputs are sampled 3 units after it.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IF_ID_Rs1       = 5'd0;
        IF_ID_Rs2       = 5'd0;
        IF_ID_UsesRs2   = 1'b0;
        ID_EX_MemRead   = 1'b0;
        ID_EX_Rd        = 5'd0;
        Branch_Taken    = 1'b0;
        EX_MEM_MemRead  = 1'b0;
        EX_MEM_MemWrite = 1'b0;
        DMem_Ack        = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #2;
    endtask

    // Packs {PC_Write, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Bubble,
    //        EX_MEM_Stall, MEM_WB_Bubble, DMem_Req, Mem_Timeout}.
    function automatic logic [8:0] ctl();
        return {PC_Write, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Bubble,
                EX_MEM_Stall, MEM_WB_Bubble, DMem_Req, Mem_Timeout};
    endfunction

    localparam logic [8:0] CtlIdle    = 9'b1_0000_0000;
    localparam logic [8:0] CtlLoadUse = 9'b0_1001_0000;
    localparam logic [8:0] CtlBranch  = 9'b1_0101_0000;
    localparam logic [8:0] CtlFreezeR = 9'b0_1010_1110;
    localparam logic [8:0] CtlAckAdv  = 9'b1_0000_0010;
    localparam logic [8:0] CtlAckBr   = 9'b1_0101_0010;
    localparam logic [8:0] CtlError   = 9'b0_1010_1101;

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #2;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", ctl(), CtlIdle);
        end
        checks++;
        if ({Stall_Count, Flush_Count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_cnt got %h exp %h", {Stall_Count, Flush_Count}, 8'h00);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        ID_EX_MemRead = 1'b1;
        ID_EX_Rd      = 5'd5;
        IF_ID_Rs1     = 5'd5;
        #2;
        checks++;
        if (ctl() !== CtlLoadUse) begin
            errors++;
            $display("FAIL lu_ctl got %b exp %b", ctl(), CtlLoadUse);
        end
        next_cycle();
        ID_EX_MemRead = 1'b0;  // bubble has reached EX
        #2;
        checks++;
        if (Stall_Count !== 4'd1) begin
            errors++;
            $display("FAIL lu_stall_cnt got %0d exp %0d", Stall_Count, 1);
        end
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL lu_clear got %b exp %b", ctl(), CtlIdle);
        end
        ID_EX_MemRead = 1'b1;
        ID_EX_Rd      = 5'd0;
        IF_ID_Rs1     = 5'd0;
        #2;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL lu_x0 got %b exp %b", ctl(), CtlIdle);
        end
        next_cycle();
        checks++;
        if (Stall_Count !== 4'd1) begin
            errors++;
            $display("FAIL lu_x0_cnt got %0d exp %0d", Stall_Count, 1);
        end
    endtask

    task automatic test_rs2_gating();
        apply_reset();
        ID_EX_MemRead = 1'b1;
        ID_EX_Rd      = 5'd7;
        IF_ID_Rs1     = 5'd3;
        IF_ID_Rs2     = 5'd7;
        IF_ID_UsesRs2 = 1'b0;
        #2;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL rs2_unused got %b exp %b", ctl(), CtlIdle);
        end
        IF_ID_UsesRs2 = 1'b1;
        #2;
        checks++;
        if (ctl() !== CtlLoadUse) begin
            errors++;
            $display("FAIL rs2_used got %b exp %b", ctl(), CtlLoadUse);
        end
        IF_ID_Rs2 = 5'd8;
        #2;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL rs2_diff got %b exp %b", ctl(), CtlIdle);
        end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        ID_EX_MemRead = 1'b1;
        ID_EX_Rd      = 5'd5;
        IF_ID_Rs1     = 5'd5;
        Branch_Taken  = 1'b1;
        #2;
        checks++;
        if (ctl() !== CtlBranch) begin
            errors++;
            $display("FAIL br_prio got %b exp %b", ctl(), CtlBranch);
        end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if ({Flush_Count, Stall_Count} !== {4'd1, 4'd0}) begin
            errors++;
            $display("FAIL br_cnt got %h exp %h", {Flush_Count, Stall_Count}, 8'h10);
        end
    endtask

    task automatic test_store_wait();
        int req_cycles = 0;
        apply_reset();
        EX_MEM_MemWrite = 1'b1;
        DMem_Ack        = 1'b1;  // spurious ack in the issue cycle must be ignored
        #2;
        if (DMem_Req) req_cycles++;
        checks++;
        if (ctl() !== CtlFreezeR) begin
            errors++;
            $display("FAIL st_issue got %b exp %b", ctl(), CtlFreezeR);
        end
        for (int i = 1; i <= 2; i++) begin
            next_cycle();
            DMem_Ack = 1'b0;
            #2;
            if (DMem_Req) req_cycles++;
            checks++;
            if (ctl() !== CtlFreezeR) begin
                errors++;
                $display("FAIL st_wait%0d got %b exp %b", i, ctl(), CtlFreezeR);
            end
        end
        next_cycle();
        DMem_Ack = 1'b1;
        #2;
        if (DMem_Req) req_cycles++;
        checks++;
        if (ctl() !== CtlAckAdv) begin
            errors++;
            $display("FAIL st_ack got %b exp %b", ctl(), CtlAckAdv);
        end
        next_cycle();
        idle_inputs();
        #2;
        if (DMem_Req) req_cycles++;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL st_run got %b exp %b", ctl(), CtlIdle);
        end
        checks++;
        if (req_cycles != 4) begin
            errors++;
            $display("FAIL st_req_len got %0d exp %0d", req_cycles, 4);
        end
        checks++;
        if (Stall_Count !== 4'd3) begin
            errors++;
            $display("FAIL st_stall_cnt got %0d exp %0d", Stall_Count, 3);
        end
    endtask

    task automatic test_branch_in_wait();
        apply_reset();
        EX_MEM_MemRead = 1'b1;
        Branch_Taken   = 1'b1;
        #2;
        checks++;
        if (ctl() !== CtlFreezeR) begin
            errors++;
            $display("FAIL bw_issue got %b exp %b", ctl(), CtlFreezeR);
        end
        next_cycle();
        #2;
        checks++;
        if (ctl() !== CtlFreezeR) begin
            errors++;
            $display("FAIL bw_wait got %b exp %b", ctl(), CtlFreezeR);
        end
        next_cycle();
        DMem_Ack = 1'b1;
        #2;
        checks++;
        if (ctl() !== CtlAckBr) begin
            errors++;
            $display("FAIL bw_ack got %b exp %b", ctl(), CtlAckBr);
        end
        next_cycle();
        idle_inputs();
        #2;
        checks++;
        if ({Flush_Count, Stall_Count} !== {4'd1, 4'd2}) begin
            errors++;
            $display("FAIL bw_cnt got %h exp %h", {Flush_Count, Stall_Count}, 8'h12);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        EX_MEM_MemRead = 1'b1;
        #2;
        checks++;
        if (ctl() !== CtlFreezeR) begin
            errors++;
            $display("FAIL to_issue got %b exp %b", ctl(), CtlFreezeR);
        end
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            #2;
            checks++;
            if (ctl() !== CtlFreezeR) begin
                errors++;
                $display("FAIL to_wait%0d got %b exp %b", i, ctl(), CtlFreezeR);
            end
        end
        next_cycle();
        DMem_Ack = 1'b1;  // a late ack cannot leave ERROR
        #2;
        checks++;
        if (ctl() !== CtlError) begin
            errors++;
            $display("FAIL to_error got %b exp %b", ctl(), CtlError);
        end
        for (int i = 0; i < 12; i++) next_cycle();
        #2;
        checks++;
        if (ctl() !== CtlError) begin
            errors++;
            $display("FAIL to_sticky got %b exp %b", ctl(), CtlError);
        end
        checks++;
        if (Stall_Count !== 4'hF) begin
            errors++;
            $display("FAIL to_sat got %0d exp %0d", Stall_Count, 15);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL to_reset_ctl got %b exp %b", ctl(), CtlIdle);
        end
        checks++;
        if ({Stall_Count, Flush_Count} !== 8'h00) begin
            errors++;
            $display("FAIL to_reset_cnt got %h exp %h", {Stall_Count, Flush_Count}, 8'h00);
        end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        EX_MEM_MemWrite = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (DMem_Req !== 1'b1) begin
            errors++;
            $display("FAIL rmw_req got %b exp %b", DMem_Req, 1'b1);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (ctl() !== CtlIdle) begin
            errors++;
            $display("FAIL rmw_drop got %b exp %b", ctl(), CtlIdle);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_rs2_gating();
        test_branch_priority();
        test_store_wait();
        test_branch_in_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
